// File: rtl/frame_loader_if.sv
// frame_loader_if: pixel-stream handshake plus image-memory write port.
//   sof, pix_valid, pix_data : pixel beat from the upstream source
//   pix_ready                : loader can take a beat
//   write_mem, x_addr,
//   y_addr, data_bit         : registered memory write (writeMem/xAddressIn/yAddressIn/dataIn)
// master = pixel source / memory side, slave = frame_loader.
interface frame_loader_if #(
    parameter int AW = 8
);
    logic          sof;
    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          pix_ready;
    logic          write_mem;
    logic [AW-1:0] x_addr;
    logic [AW-1:0] y_addr;
    logic          data_bit;

    modport master (
        output sof, pix_valid, pix_data,
        input  pix_ready, write_mem, x_addr, y_addr, data_bit
    );

    modport slave (
        input  sof, pix_valid, pix_data,
        output pix_ready, write_mem, x_addr, y_addr, data_bit
    );
endinterface

// File: rtl/frame_loader.sv
// frame_loader: binarises a raster pixel stream into the median-filter image
// memory, then holds start until the filter reports the whole image done.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : frame_loader_if.slave (pixel stream in, memory write out)
//   bin_thresh   : pixel >= bin_thresh writes a 1
//   start        : filter run enable, high throughout RUN
//   filter_done  : fullImageDone from the filter, only honoured in RUN
//   busy         : loader not idle
//   sof_err      : sticky, sof arrived in the middle of a frame
//   frame_count  : completed frames, wrapping 16-bit count
module frame_loader #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    frame_loader_if.slave       bus,
    input  logic [7:0]          bin_thresh,
    output logic                start,
    input  logic                filter_done,
    output logic                busy,
    output logic                sof_err,
    output logic [15:0]         frame_count
);

    typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_t;

    localparam logic [AW-1:0] LAST_X = AW'(IMG_W - 1);
    localparam logic [AW-1:0] LAST_Y = AW'(IMG_H - 1);

    state_t        state, state_next;
    logic [AW-1:0] col, col_next;
    logic [AW-1:0] row, row_next;
    logic          ready, accept;
    logic          wr_en;
    logic [AW-1:0] wr_x, wr_y;
    logic          err_set, done;

    logic          write_mem_q, data_bit_q;
    logic [AW-1:0] x_addr_q, y_addr_q;

    // Held low during reset so no beat can be taken while the loader clears.
    assign ready  = ((state == IDLE) || (state == LOAD)) && !reset;
    assign accept = bus.pix_valid && ready;

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        wr_en      = 1'b0;
        wr_x       = col;
        wr_y       = row;
        err_set    = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && bus.sof) begin
                    wr_en      = 1'b1;
                    wr_x       = '0;
                    wr_y       = '0;
                    col_next   = AW'(1);
                    row_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (bus.sof) begin
                        // Restart the frame in place: this beat becomes pixel (0,0).
                        err_set  = 1'b1;
                        wr_x     = '0;
                        wr_y     = '0;
                        col_next = AW'(1);
                        row_next = '0;
                    end else if (col == LAST_X) begin
                        col_next = '0;
                        if (row == LAST_Y) begin
                            row_next   = '0;
                            state_next = ARM;
                        end else begin
                            row_next = row + AW'(1);
                        end
                    end else begin
                        col_next = col + AW'(1);
                    end
                end
            end
            ARM: state_next = RUN;
            RUN: begin
                if (filter_done) begin
                    done       = 1'b1;
                    col_next   = '0;
                    row_next   = '0;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            write_mem_q <= 1'b0;
            x_addr_q    <= '0;
            y_addr_q    <= '0;
            data_bit_q  <= 1'b0;
            start       <= 1'b0;
            sof_err     <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            col         <= col_next;
            row         <= row_next;
            write_mem_q <= wr_en;
            if (wr_en) begin
                x_addr_q   <= wr_x;
                y_addr_q   <= wr_y;
                data_bit_q <= (bus.pix_data >= bin_thresh);
            end
            // ARM sits between the last write and start, so they never overlap.
            start <= (state_next == RUN);
            if (err_set) sof_err <= 1'b1;
            if (done) frame_count <= frame_count + 16'd1;
        end
    end

    assign bus.pix_ready = ready;
    assign bus.write_mem = write_mem_q;
    assign bus.x_addr    = x_addr_q;
    assign bus.y_addr    = y_addr_q;
    assign bus.data_bit  = data_bit_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: randomized scoreboard bench for frame_loader (4x3 image).
// The driver predicts each write from a raster-position model and queues it;
// the monitor pops and compares whenever the DUT strobes write_mem.
module tb_frame_loader;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  bin_thresh = 8'h00;
    logic        start;
    logic        filter_done = 1'b0;
    logic        busy;
    logic        sof_err;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    frame_loader_if #(.AW(AW)) bus ();

    frame_loader #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .bin_thresh  (bin_thresh),
        .start       (start),
        .filter_done (filter_done),
        .busy        (busy),
        .sof_err     (sof_err),
        .frame_count (frame_count)
    );

    typedef struct {
        int x;
        int y;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Reference model: linear raster position within the current frame.
    int  pos = 0;
    bit  in_frame = 0;
    bit  frame_full = 0;
    int  exp_err = 0;
    int  exp_frames = 0;

    function automatic void check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_accept(input bit s, input logic [7:0] d);
        if (!in_frame && !s) return;
        if (s) begin
            if (in_frame) exp_err = 1;
            pos = 0;
            in_frame = 1;
        end
        exp_q.push_back('{pos % W, pos / W, (d >= bin_thresh) ? 1 : 0});
        pos++;
        if (pos == W * H) begin
            frame_full = 1;
            in_frame = 0;
        end
    endfunction

    // Monitor: every write strobe must match the oldest predicted write.
    always @(posedge clk) begin
        #1;
        if (bus.write_mem === 1'b1) begin
            check("no_start_with_write", int'(start), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", int'(bus.write_mem), 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("x_addr", int'(bus.x_addr), e.x);
                check("y_addr", int'(bus.y_addr), e.y);
                check("data_bit", int'(bus.data_bit), e.d);
            end
        end
    end

    task automatic beat(input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        bus.pix_valid = v;
        bus.sof = s;
        bus.pix_data = d;
        check("pix_ready", int'(bus.pix_ready), frame_full ? 0 : 1);
        if (v && !frame_full) model_accept(s, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        filter_done = 1'b0;
        @(negedge clk);
        check("rst_write_mem", int'(bus.write_mem), 0);
        check("rst_addr", int'({bus.x_addr, bus.y_addr, bus.data_bit}), 0);
        check("rst_start", int'(start), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sof_err", int'(sof_err), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_pix_ready", int'(bus.pix_ready), 0);
        check("rst_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        reset = 1'b0;
        pos = 0;
        in_frame = 0;
        frame_full = 0;
        exp_err = 0;
        exp_frames = 0;
        @(negedge clk);
        check("post_rst_ready", int'(bus.pix_ready), 1);
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < W * H; i++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) beat(1'b0, 1'($urandom), 8'($urandom));
            end
            beat(1'b1, i == 0, 8'($urandom));
        end
    endtask

    // After the final beat: one ARM cycle, then start.
    task automatic expect_start();
        int k;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.sof = 1'b0;
            k = i;
            check("ready_low_after_frame", int'(bus.pix_ready), 0);
            if (start === 1'b1) break;
            k = 11;
        end
        check("start_latency", k, 2);
        check("queue_drained", exp_q.size(), 0);
        check("busy_in_run", int'(busy), 1);
        check("sof_err", int'(sof_err), exp_err);
    endtask

    task automatic run_done(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("start_held", int'(start), 1);
            check("ready_low_in_run", int'(bus.pix_ready), 0);
        end
        @(negedge clk);
        filter_done = 1'b1;
        @(negedge clk);
        filter_done = 1'b0;
        exp_frames = (exp_frames + 1) & 16'hFFFF;
        frame_full = 0;
        pos = 0;
        check("start_cleared", int'(start), 0);
        check("frame_count", int'(frame_count), exp_frames);
        check("ready_after_done", int'(bus.pix_ready), 1);
        check("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof = 1'b0;
        bus.pix_data = 8'h00;
        do_reset();

        // Ramp frame: data 0x00..0xB0, threshold 0x50 (includes the equal case).
        bin_thresh = 8'h50;
        for (int i = 0; i < W * H; i++) beat(1'b1, i == 0, 8'(i * 16));
        expect_start();
        run_done(50);

        // Same frame with valid toggled every other cycle.
        for (int i = 0; i < W * H; i++) begin
            beat(1'b0, 1'b0, 8'hFF);
            beat(1'b1, i == 0, 8'(i * 16));
        end
        expect_start();
        run_done(3);

        // Beats without sof in IDLE are dropped; filter_done in IDLE is ignored.
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 8'($urandom));
        @(negedge clk);
        bus.pix_valid = 1'b0;
        filter_done = 1'b1;
        @(negedge clk);
        filter_done = 1'b0;
        check("idle_busy", int'(busy), 0);
        check("idle_frame_count", int'(frame_count), exp_frames);

        // Mid-frame sof on beat 7 restarts the frame and sets sof_err.
        bin_thresh = 8'($urandom);
        for (int i = 0; i < 6; i++) beat(1'b1, i == 0, 8'($urandom));
        beat(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < W * H - 1; i++) begin
            beat(1'b1, 1'b0, 8'($urandom));
            if (i < W * H - 2) check("no_early_start", int'(start), 0);
        end
        expect_start();
        run_done(2);

        // Reset mid-load, then in RUN; each followed by a clean frame.
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, 8'($urandom));
        do_reset();
        bin_thresh = 8'($urandom);
        send_frame(1'b1);
        expect_start();
        do_reset();
        send_frame(1'b0);
        expect_start();
        run_done(1);

        // Random frames with random thresholds and gaps.
        for (int f = 0; f < 6; f++) begin
            bin_thresh = 8'($urandom);
            send_frame(1'b1);
            expect_start();
            run_done($urandom_range(0, 5));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
